// File: rtl/led_recv.sv
// Serial LED-strip receiver: synchronises cki/sdi, detects the 32-zero start frame,
// unpacks LED_NUM 32-bit LED frames and checks the all-ones end frame.
// Optional error counter output enabled by defining LED_RECV_ERR_CNT_EN.
module led_recv #(
    parameter int LED_NUM     = 4,
    parameter int TIMEOUT_CNT = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cki,
    input  logic        sdi,
    output logic        wr,
    output logic [23:0] led_data,
    output logic [4:0]  led_bright,
    output logic [10:0] led_idx,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy
`ifdef LED_RECV_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam int               TO_W     = $clog2(TIMEOUT_CNT + 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CNT);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CNT - 1);
    localparam logic [10:0]      LAST_IDX = 11'(LED_NUM - 1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, END} state_t;

    function automatic logic [5:0] bit_next(input logic [5:0] cnt);
        return (cnt == 6'd31) ? 6'd0 : cnt + 6'd1;
    endfunction

    function automatic logic [TO_W-1:0] to_sat_inc(input logic [TO_W-1:0] cnt);
        return (cnt == TO_MAX) ? cnt : cnt + 1'b1;
    endfunction

    state_t           state;
    logic             cki_p0, cki_p1, cki_p2;
    logic             sdi_p0, sdi_p1;
    logic             rise, bit_in;
    logic [30:0]      shreg;
    logic [31:0]      frame_word;
    logic [5:0]       bit_cnt, zero_cnt;
    logic [10:0]      frame_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             end_ok;

    // Stage p0/p1: two-flop synchronisers; p2: cki edge detector
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cki_p0 <= 1'b1;
            cki_p1 <= 1'b1;
            cki_p2 <= 1'b1;
            sdi_p0 <= 1'b0;
            sdi_p1 <= 1'b0;
        end else begin
            cki_p0 <= cki;
            cki_p1 <= cki_p0;
            cki_p2 <= cki_p1;
            sdi_p0 <= sdi;
            sdi_p1 <= sdi_p0;
        end
    end

    assign rise       = cki_p1 & ~cki_p2;
    assign bit_in     = sdi_p1;
    assign frame_word = {shreg, bit_in};
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            zero_cnt   <= '0;
            frame_cnt  <= '0;
            to_cnt     <= '0;
            end_ok     <= 1'b0;
            wr         <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            led_data   <= '0;
            led_bright <= '0;
            led_idx    <= '0;
        end else begin
            wr         <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (state == IDLE) begin
                to_cnt <= '0;
                if (zero_cnt == 6'd32) begin
                    zero_cnt <= '0;
                    state    <= SYNC;
                end else if (rise) begin
                    zero_cnt <= bit_in ? 6'd0 : zero_cnt + 6'd1;
                end
            end else if (!rise) begin
                // No cki edge while a transfer is open: abort once the budget is spent
                if (to_cnt == TO_LAST) begin
                    frame_err <= 1'b1;
                    bit_cnt   <= '0;
                    zero_cnt  <= '0;
                    frame_cnt <= '0;
                    to_cnt    <= '0;
                    state     <= IDLE;
                end else begin
                    to_cnt <= to_sat_inc(to_cnt);
                end
            end else begin
                to_cnt <= '0;
                case (state)
                    SYNC: begin
                        if (bit_in) begin
                            shreg   <= 31'd1;
                            bit_cnt <= 6'd1;
                            state   <= DATA;
                        end
                    end
                    DATA: begin
                        shreg   <= frame_word[30:0];
                        bit_cnt <= bit_next(bit_cnt);
                        if (bit_cnt == 6'd31) begin
                            if (frame_word[31:29] == 3'b111) begin
                                wr         <= 1'b1;
                                led_data   <= frame_word[23:0];
                                led_bright <= frame_word[28:24];
                                led_idx    <= frame_cnt;
                                if (frame_cnt == LAST_IDX) begin
                                    end_ok <= 1'b1;
                                    state  <= END;
                                end else begin
                                    frame_cnt <= frame_cnt + 11'd1;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                frame_cnt <= '0;
                                state     <= IDLE;
                            end
                        end
                    end
                    END: begin
                        bit_cnt <= bit_next(bit_cnt);
                        end_ok  <= end_ok & bit_in;
                        if (bit_cnt == 6'd31) begin
                            frame_done <= end_ok & bit_in;
                            frame_err  <= ~(end_ok & bit_in);
                            frame_cnt  <= '0;
                            state      <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef LED_RECV_ERR_CNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            err_cnt <= '0;
        else if (frame_err)
            err_cnt <= sat_inc8(err_cnt);
    end
`endif

endmodule

// File: tb/tb_led_recv.sv
// Directed bench for led_recv: start/LED/end frames, bad header, timeout,
// bad end frame and mid-transfer reset, with hand-computed expectations.
module tb_led_recv;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cki;
    logic        sdi;
    logic        wr;
    logic [23:0] led_data;
    logic [4:0]  led_bright;
    logic [10:0] led_idx;
    logic        frame_done;
    logic        frame_err;
    logic        busy;
`ifdef LED_RECV_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    led_recv #(.LED_NUM(4), .TIMEOUT_CNT(64)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cki        (cki),
        .sdi        (sdi),
        .wr         (wr),
        .led_data   (led_data),
        .led_bright (led_bright),
        .led_idx    (led_idx),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
`ifdef LED_RECV_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_wr = 0, n_done = 0, n_err = 0, excl_viol = 0, err_cyc_last = 0;
    logic [23:0] wr_data_q[$];
    logic [10:0] wr_idx_q[$];
    logic [4:0]  wr_bright_q[$];

    logic [31:0] frames [4] = '{32'hFF112233, 32'hFF445566, 32'hFF778899, 32'hFFAABBCC};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr) begin
            n_wr++;
            wr_data_q.push_back(led_data);
            wr_idx_q.push_back(led_idx);
            wr_bright_q.push_back(led_bright);
        end
        if (frame_done) n_done++;
        if (frame_err) begin
            n_err++;
            err_cyc_last = cyc;
        end
        if (int'(wr) + int'(frame_done) + int'(frame_err) > 1) excl_viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, output int rise_cyc);
        @(negedge clk);
        cki = 1'b0;
        sdi = b;
        repeat (3) @(negedge clk);
        cki = 1'b1;
        rise_cyc = cyc;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] w, input int nbits);
        int rc;
        for (int i = 0; i < nbits; i++) send_bit(w[31-i], rc);
    endtask

    task automatic send_const(input logic b, input int n);
        int rc;
        for (int i = 0; i < n; i++) send_bit(b, rc);
    endtask

    task automatic check_frames(input int base, input int nfr);
        for (int i = 0; i < nfr; i++) begin
            if (base + i < wr_data_q.size()) begin
                chk($sformatf("led_data[%0d]", i), 32'(wr_data_q[base+i]), 32'(frames[i][23:0]));
                chk($sformatf("led_idx[%0d]", i), 32'(wr_idx_q[base+i]), i);
                chk($sformatf("led_bright[%0d]", i), 32'(wr_bright_q[base+i]), 32'h1F);
            end else begin
                chk($sformatf("wr_present[%0d]", i), 0, 1);
            end
        end
    endtask

    task automatic check_outputs_zero(input string pfx);
        chk({pfx, "_wr"}, 32'(wr), 0);
        chk({pfx, "_led_data"}, 32'(led_data), 0);
        chk({pfx, "_led_bright"}, 32'(led_bright), 0);
        chk({pfx, "_led_idx"}, 32'(led_idx), 0);
        chk({pfx, "_frame_done"}, 32'(frame_done), 0);
        chk({pfx, "_frame_err"}, 32'(frame_err), 0);
        chk({pfx, "_busy"}, 32'(busy), 0);
`ifdef LED_RECV_ERR_CNT_EN
        chk({pfx, "_err_cnt"}, 32'(err_cnt), 0);
`endif
    endtask

    task automatic full_transfer(input int nzeros);
        send_const(1'b0, nzeros);
        for (int f = 0; f < 4; f++) send_bits(frames[f], 32);
        send_const(1'b1, 32);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int b_wr, b_done, b_err, rc;
        rstn = 1'b0;
        cki  = 1'b1;
        sdi  = 1'b0;
        repeat (5) @(negedge clk);
        check_outputs_zero("reset");
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // Nominal transfer, exact 32-zero start frame
        b_wr = n_wr; b_done = n_done; b_err = n_err;
        full_transfer(32);
        chk("s1_wr_count", n_wr - b_wr, 4);
        check_frames(b_wr, 4);
        chk("s1_done_count", n_done - b_done, 1);
        chk("s1_err_count", n_err - b_err, 0);
        chk("s1_busy", 32'(busy), 0);

        // Extra zeros absorbed in SYNC
        b_wr = n_wr; b_done = n_done; b_err = n_err;
        full_transfer(40);
        chk("s2_wr_count", n_wr - b_wr, 4);
        check_frames(b_wr, 4);
        chk("s2_done_count", n_done - b_done, 1);
        chk("s2_err_count", n_err - b_err, 0);

        // Bad header on frame 1
        b_wr = n_wr; b_done = n_done; b_err = n_err;
        send_const(1'b0, 32);
        send_bits(frames[0], 32);
        send_bits(32'h7F000000, 32);
        repeat (8) @(negedge clk);
        chk("s3_wr_count", n_wr - b_wr, 1);
        check_frames(b_wr, 1);
        chk("s3_err_count", n_err - b_err, 1);
        chk("s3_done_count", n_done - b_done, 0);
        chk("s3_busy", 32'(busy), 0);
`ifdef LED_RECV_ERR_CNT_EN
        chk("s3_err_cnt", 32'(err_cnt), 1);
`endif

        // cki stalls high after bit 10 of frame 2
        b_wr = n_wr; b_done = n_done; b_err = n_err;
        send_const(1'b0, 32);
        send_bits(frames[0], 32);
        send_bits(frames[1], 32);
        for (int i = 0; i < 11; i++) send_bit(frames[2][31-i], rc);
        repeat (100) @(negedge clk);
        chk("s4_wr_count", n_wr - b_wr, 2);
        chk("s4_err_count", n_err - b_err, 1);
        // 2 synchroniser flops + edge flop, then 64 idle cycles
        chk("s4_err_latency", err_cyc_last - rc, 67);
        chk("s4_busy", 32'(busy), 0);

        // Corrupt end frame, then a back-to-back good transfer
        b_wr = n_wr; b_done = n_done; b_err = n_err;
        send_const(1'b0, 32);
        for (int f = 0; f < 4; f++) send_bits(frames[f], 32);
        send_bits(32'hFFFFFFFE, 32);
        repeat (8) @(negedge clk);
        chk("s5_wr_count", n_wr - b_wr, 4);
        chk("s5_done_count", n_done - b_done, 0);
        chk("s5_err_count", n_err - b_err, 1);
        b_wr = n_wr; b_done = n_done; b_err = n_err;
        full_transfer(32);
        chk("s5b_wr_count", n_wr - b_wr, 4);
        check_frames(b_wr, 4);
        chk("s5b_done_count", n_done - b_done, 1);
        chk("s5b_err_count", n_err - b_err, 0);

        // Reset mid-frame 1
        send_const(1'b0, 32);
        send_bits(frames[0], 32);
        send_bits(frames[1], 16);
        b_wr = n_wr; b_done = n_done; b_err = n_err;
        #3 rstn = 1'b0;
        cki = 1'b1;
        sdi = 1'b0;
        repeat (4) @(negedge clk);
        check_outputs_zero("midrst");
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        chk("s6_pulses", (n_wr - b_wr) + (n_done - b_done) + (n_err - b_err), 0);
        b_wr = n_wr; b_done = n_done; b_err = n_err;
        full_transfer(32);
        chk("s6_wr_count", n_wr - b_wr, 4);
        check_frames(b_wr, 4);
        chk("s6_done_count", n_done - b_done, 1);
        chk("s6_err_count", n_err - b_err, 0);

        chk("exclusive_pulses", excl_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
